// File: rtl/icache_bk_control.sv
// Instruction-cache control FSM: hit/miss sequencing, line fill, full-set invalidation sweep
// and a saturating miss counter. Array enables are decoded straight from the state.
module icache_bk_control #(
  parameter int s_index = 3,
  parameter int s_cnt   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  output logic               mem_resp,
  input  logic               flush,
  output logic               flush_busy,
  output logic [s_index-1:0] flush_idx,
  input  logic               is_hit,
  output logic               load_data,
  output logic               load_tag,
  output logic               load_valid,
  output logic               valid_in,
  output logic               pmem_read,
  input  logic               pmem_resp,
  output logic [s_cnt-1:0]   miss_count
);

  typedef enum logic [2:0] {IDLE, COMPARE, FETCH, WRITE, FLUSH} state_t;

  localparam logic [s_index-1:0] last_idx = '1;
  localparam logic [s_cnt-1:0]   cnt_max  = '1;

  state_t             state_reg;
  logic [s_index-1:0] flush_idx_reg;
  logic [s_cnt-1:0]   miss_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      flush_idx_reg  <= '0;
      miss_count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // flush outranks a simultaneous fetch; the fetch is served after the sweep
          if (flush) begin
            state_reg     <= FLUSH;
            flush_idx_reg <= '0;
          end else if (mem_read) begin
            state_reg <= COMPARE;
          end
        end
        COMPARE: begin
          if (!mem_read || is_hit) begin
            state_reg <= IDLE;
          end else begin
            state_reg <= FETCH;
            if (miss_count_reg != cnt_max)
              miss_count_reg <= miss_count_reg + 1'b1;
          end
        end
        FETCH: begin
          // a dropped mem_read does not abort the fill; the line is still written
          if (pmem_resp)
            state_reg <= WRITE;
        end
        WRITE: begin
          state_reg <= mem_read ? COMPARE : IDLE;
        end
        FLUSH: begin
          if (flush_idx_reg == last_idx) begin
            state_reg     <= IDLE;
            flush_idx_reg <= '0;
          end else begin
            flush_idx_reg <= flush_idx_reg + 1'b1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          flush_idx_reg <= '0;
        end
      endcase
    end
  end

  // mem_resp and the fill enables depend on same-cycle inputs so hit latency stays at two cycles
  always_comb begin
    mem_resp   = 1'b0;
    pmem_read  = 1'b0;
    load_data  = 1'b0;
    load_tag   = 1'b0;
    load_valid = 1'b0;
    valid_in   = 1'b0;
    case (state_reg)
      COMPARE: mem_resp = mem_read && is_hit;
      FETCH: begin
        pmem_read  = 1'b1;
        load_data  = pmem_resp;
        load_tag   = pmem_resp;
        load_valid = pmem_resp;
        valid_in   = pmem_resp;
      end
      FLUSH: load_valid = 1'b1;
      default: ;
    endcase
  end

  assign flush_busy = (state_reg == FLUSH);
  assign flush_idx  = flush_idx_reg;
  assign miss_count = miss_count_reg;

endmodule

// File: tb/tb_icache_bk_control.sv
// Bench for icache_bk_control: directed transaction table, hand sequences for flush,
// compare-abort and reset mid-fill, then random transactions against a transaction-level model.
module tb_icache_bk_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        flush = 1'b0;
  logic        is_hit = 1'b0;
  logic        pmem_resp = 1'b0;

  logic        mem_resp, flush_busy, load_data, load_tag, load_valid, valid_in, pmem_read;
  logic [2:0]  flush_idx;
  logic [15:0] miss_count;

  logic        sat_mem_resp, sat_flush_busy, sat_load_data, sat_load_tag;
  logic        sat_load_valid, sat_valid_in, sat_pmem_read;
  logic [2:0]  sat_flush_idx;
  logic [1:0]  sat_miss_count;

  int checks = 0;
  int failures = 0;
  int miss_total = 0;

  always #5 clk = ~clk;

  icache_bk_control dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_resp(mem_resp),
    .flush(flush), .flush_busy(flush_busy), .flush_idx(flush_idx),
    .is_hit(is_hit), .load_data(load_data), .load_tag(load_tag),
    .load_valid(load_valid), .valid_in(valid_in), .pmem_read(pmem_read),
    .pmem_resp(pmem_resp), .miss_count(miss_count)
  );

  icache_bk_control #(.s_index(3), .s_cnt(2)) dut_sat (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_resp(sat_mem_resp),
    .flush(flush), .flush_busy(sat_flush_busy), .flush_idx(sat_flush_idx),
    .is_hit(is_hit), .load_data(sat_load_data), .load_tag(sat_load_tag),
    .load_valid(sat_load_valid), .valid_in(sat_valid_in), .pmem_read(sat_pmem_read),
    .pmem_resp(pmem_resp), .miss_count(sat_miss_count)
  );

  typedef struct {
    bit miss;
    int lat;
    bit abandon;
    bit noise;
    int exp_resp;
    int exp_pr;
    int exp_ld;
  } vec_t;

  function automatic void check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endfunction

  function automatic void check_counts();
    check("miss_count", longint'(miss_count), (miss_total > 65535) ? 65535 : miss_total);
    check("miss_count_sat", longint'(sat_miss_count), (miss_total > 3) ? 3 : miss_total);
  endfunction

  // One CPU read (or abandoned read); memory answers after pmem_read has been high lat cycles.
  task automatic read_txn(input bit miss, input int lat, input bit abandon, input bit noise,
                          output int resp_at, output int pr_cnt, output int ld_cnt,
                          output int bad_cnt);
    bit filled;
    resp_at = 0; pr_cnt = 0; ld_cnt = 0; bad_cnt = 0; filled = 0;
    for (int c = 1; c <= lat + 10; c++) begin
      @(negedge clk);
      mem_read = !(abandon && pr_cnt > 0);
      is_hit   = !miss || filled;
      flush    = noise && pr_cnt > 0 && pr_cnt < lat;
      #1;
      if (pmem_read) pr_cnt++;
      pmem_resp = pmem_read && (pr_cnt == lat);
      #1;
      if (load_data && load_tag && load_valid && valid_in) begin
        ld_cnt++;
        filled = 1;
      end else if (load_data || load_tag || load_valid || valid_in) begin
        bad_cnt++;
      end
      if (flush_busy) bad_cnt++;
      if (mem_resp) begin
        resp_at = c;
        break;
      end
    end
    @(negedge clk);
    mem_read = 0; is_hit = 0; flush = 0; pmem_resp = 0;
  endtask

  // Flush request raised for one IDLE cycle, optionally together with a read that hits.
  task automatic flush_txn(input bit with_read, output int busy_cnt, output int idx_bad,
                           output int en_bad, output int resp_at);
    busy_cnt = 0; idx_bad = 0; en_bad = 0; resp_at = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      flush     = (c == 1);
      mem_read  = with_read && (resp_at == 0);
      is_hit    = 1;
      pmem_resp = 0;
      #2;
      if (flush_busy) begin
        if (int'(flush_idx) != busy_cnt) idx_bad++;
        if (!(load_valid && !valid_in && !load_data && !load_tag)) en_bad++;
        busy_cnt++;
      end else if (flush_idx != 3'd0) begin
        idx_bad++;
      end
      if (pmem_read) en_bad++;
      if (mem_resp) begin
        if (resp_at == 0) resp_at = c;
        if (flush_busy) en_bad++;
      end
    end
    @(negedge clk);
    mem_read = 0; is_hit = 0; flush = 0;
  endtask

  task automatic run_read(input string tag, input vec_t v);
    int resp_at, pr_cnt, ld_cnt, bad_cnt;
    read_txn(v.miss, v.lat, v.abandon, v.noise, resp_at, pr_cnt, ld_cnt, bad_cnt);
    if (v.miss || v.abandon) miss_total++;
    $display("%s miss=%0d lat=%0d abandon=%0d noise=%0d resp_at=%0d pmem_cycles=%0d loads=%0d count=%0d",
             tag, v.miss, v.lat, v.abandon, v.noise, resp_at, pr_cnt, ld_cnt, miss_count);
    check({tag, "_resp_cycle"}, resp_at, v.exp_resp);
    check({tag, "_pmem_cycles"}, pr_cnt, v.exp_pr);
    check({tag, "_loads"}, ld_cnt, v.exp_ld);
    check({tag, "_stray_enables"}, bad_cnt, 0);
    check_counts();
  endtask

  task automatic run_flush(input string tag, input bit with_read);
    int busy_cnt, idx_bad, en_bad, resp_at;
    flush_txn(with_read, busy_cnt, idx_bad, en_bad, resp_at);
    $display("%s with_read=%0d busy_cycles=%0d resp_at=%0d", tag, with_read, busy_cnt, resp_at);
    check({tag, "_busy_cycles"}, busy_cnt, 8);
    check({tag, "_idx_seq"}, idx_bad, 0);
    check({tag, "_enables"}, en_bad, 0);
    check({tag, "_resp_cycle"}, resp_at, with_read ? 11 : 0);
    check_counts();
  endtask

  // Expected values come from the transaction rules: hit answers at cycle 2,
  // a miss of latency L answers at L+4 (COMPARE, L fetch cycles, WRITE, COMPARE).
  function automatic vec_t make_vec(input int kind, input int lat, input bit noise);
    vec_t v;
    v.miss = (kind != 0); v.lat = lat; v.abandon = (kind == 2); v.noise = noise;
    v.exp_resp = (kind == 0) ? 2 : (kind == 1) ? lat + 4 : 0;
    v.exp_pr   = (kind == 0) ? 0 : lat;
    v.exp_ld   = (kind == 0) ? 0 : 1;
    return v;
  endfunction

  initial begin
    vec_t table_v[5];
    int pr_seen, resp_seen;

    table_v[0] = '{miss: 0, lat: 1, abandon: 0, noise: 0, exp_resp: 2, exp_pr: 0, exp_ld: 0};
    table_v[1] = '{miss: 1, lat: 5, abandon: 0, noise: 0, exp_resp: 9, exp_pr: 5, exp_ld: 1};
    table_v[2] = '{miss: 1, lat: 1, abandon: 0, noise: 1, exp_resp: 5, exp_pr: 1, exp_ld: 1};
    table_v[3] = '{miss: 1, lat: 3, abandon: 1, noise: 0, exp_resp: 0, exp_pr: 3, exp_ld: 1};
    table_v[4] = '{miss: 1, lat: 4, abandon: 0, noise: 1, exp_resp: 8, exp_pr: 4, exp_ld: 1};

    // Reset values
    #12;
    check("reset_outputs",
          {mem_resp, pmem_read, load_data, load_tag, load_valid, valid_in, flush_busy}, 0);
    check("reset_flush_idx", flush_idx, 0);
    check("reset_miss_count", miss_count, 0);
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 5; i++) run_read($sformatf("table%0d", i), table_v[i]);

    run_flush("flush_read", 1'b1);
    run_flush("flush_only", 1'b0);

    // mem_read withdrawn in COMPARE: no response, no fill, no count
    pr_seen = 0; resp_seen = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      mem_read = (c == 1); is_hit = 0;
      #2;
      if (pmem_read) pr_seen++;
      if (mem_resp) resp_seen++;
    end
    $display("compare_abort pmem_cycles=%0d resps=%0d count=%0d", pr_seen, resp_seen, miss_count);
    check("abort_pmem_cycles", pr_seen, 0);
    check("abort_resps", resp_seen, 0);
    check_counts();

    for (int n = 0; n < 40; n++) begin
      int kind, lat;
      bit noise;
      kind  = $urandom_range(0, 3);
      lat   = $urandom_range(1, 6);
      noise = 1'($urandom_range(0, 1));
      if (kind == 3) run_flush($sformatf("rand%0d_flush", n), noise);
      else run_read($sformatf("rand%0d", n), make_vec(kind, lat, noise));
    end

    // Reset two cycles into FETCH
    @(negedge clk);
    mem_read = 1; is_hit = 0; pmem_resp = 0;
    repeat (3) @(negedge clk);
    #2;
    check("pre_reset_pmem_read", pmem_read, 1);
    rst = 1;
    #1;
    $display("reset_mid_fetch pmem_read=%0d count=%0d", pmem_read, miss_count);
    check("rst_outputs",
          {mem_resp, pmem_read, load_data, load_tag, load_valid, valid_in, flush_busy}, 0);
    check("rst_flush_idx", flush_idx, 0);
    miss_total = 0;
    check_counts();
    @(negedge clk);
    mem_read = 0;
    rst = 0;

    run_read("post_reset_hit", make_vec(0, 1, 0));
    run_read("post_reset_miss", make_vec(1, 2, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
